// File: rtl/jpeg_rle_encoder_if.sv
// jpeg_rle_encoder_if: coefficient-in / symbol-out stream bundle for the JPEG RLE stage
interface jpeg_rle_encoder_if #(
    parameter int COEF_W = 12,
    parameter int SIZE_W = 4,
    parameter int RUN_W  = 4
);
    logic              in_valid;
    logic              in_ready;
    logic [COEF_W-1:0] in_coef;
    logic              in_zero;
    logic              out_valid;
    logic              out_ready;
    logic [RUN_W-1:0]  out_run;
    logic [SIZE_W-1:0] out_size;
    logic [COEF_W-1:0] out_amp;
    logic              out_dc;
    logic              out_eob;
    logic              out_zrl;
    logic              err;
    modport master (
        output in_valid, in_coef, in_zero, out_ready,
        input  in_ready, out_valid, out_run, out_size, out_amp, out_dc, out_eob, out_zrl, err
    );
    modport slave (
        input  in_valid, in_coef, in_zero, out_ready,
        output in_ready, out_valid, out_run, out_size, out_amp, out_dc, out_eob, out_zrl, err
    );
endinterface

// File: rtl/jpeg_rle_encoder.sv
// jpeg_rle_encoder: zig-zag coefficient stream to JPEG DC/AC/ZRL/EOB (run,size,amp) symbols.
// Define JPEG_RLE_ERRCHK_EN to enable the sticky in_zero vs. coefficient mismatch flag.
module jpeg_rle_encoder #(
    parameter int COEF_W = 12,
    parameter int SIZE_W = 4,
    parameter int RUN_W  = 4
) (
    input logic clk,
    input logic rst_n,
    jpeg_rle_encoder_if.slave bus
);
    typedef enum logic {ACCEPT, ZRL_DRAIN} state_t;
    typedef struct packed {
        logic [RUN_W-1:0]  run;
        logic [SIZE_W-1:0] size;
        logic [COEF_W-1:0] amp;
        logic              dc;
        logic              eob;
        logic              zrl;
    } sym_t;

    localparam sym_t ZRL_SYM = {{RUN_W{1'b1}}, {(SIZE_W + COEF_W){1'b0}}, 3'b001};
    localparam sym_t EOB_SYM = {{(RUN_W + SIZE_W + COEF_W){1'b0}}, 3'b010};

    state_t            state, state_d;
    logic [5:0]        idx, idx_d;
    logic [RUN_W-1:0]  run, run_d;
    logic [1:0]        zpend, zpend_d;
    sym_t              hold, hold_d;
    sym_t              sym_q, sym_d;
    logic              valid_q, valid_d;
    logic [COEF_W-1:0] mag;
    logic [COEF_W-1:0] amp;
    logic [SIZE_W-1:0] cat;
    logic              accept;
    logic              pop;

    assign bus.in_ready = (state == ACCEPT) & (~valid_q | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign pop          = valid_q & bus.out_ready;

    // Category and one's-complement amplitude; the zero flag overrides the coefficient.
    always_comb begin
        mag = bus.in_coef[COEF_W-1] ? -bus.in_coef : bus.in_coef;
        cat = '0;
        for (int i = 0; i < COEF_W; i++)
            if (mag[i]) cat = SIZE_W'(i + 1);
        amp = (bus.in_coef[COEF_W-1] ? bus.in_coef - 1'b1 : bus.in_coef) & ~({COEF_W{1'b1}} << cat);
        cat = bus.in_zero ? '0 : cat;
        amp = bus.in_zero ? '0 : amp;
    end

    always_comb begin
        state_d = state;
        idx_d   = idx;
        run_d   = run;
        zpend_d = zpend;
        hold_d  = hold;
        sym_d   = sym_q;
        valid_d = valid_q & ~bus.out_ready;
        if (state == ZRL_DRAIN) begin
            if (pop) begin
                valid_d = 1'b1;
                sym_d   = zpend != 0 ? ZRL_SYM : hold;
                zpend_d = zpend != 0 ? zpend - 1'b1 : zpend;
                state_d = zpend != 0 ? ZRL_DRAIN : ACCEPT;
            end
        end else if (accept) begin
            idx_d = idx + 1'b1;
            if (idx == 0) begin
                valid_d = 1'b1;
                sym_d   = {{RUN_W{1'b0}}, cat, amp, 3'b100};
            end else if (bus.in_zero && idx == 6'd63) begin
                valid_d = 1'b1;
                sym_d   = EOB_SYM;
                run_d   = '0;
                zpend_d = '0;
            end else if (bus.in_zero) begin
                // 4-bit run wraps 15->0 exactly when a full 16-zero group is banked
                run_d   = run + 1'b1;
                zpend_d = run == {RUN_W{1'b1}} ? zpend + 1'b1 : zpend;
            end else begin
                valid_d = 1'b1;
                run_d   = '0;
                hold_d  = {run, cat, amp, 3'b000};
                sym_d   = zpend != 0 ? ZRL_SYM : {run, cat, amp, 3'b000};
                zpend_d = zpend != 0 ? zpend - 1'b1 : zpend;
                state_d = zpend != 0 ? ZRL_DRAIN : ACCEPT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= ACCEPT;
            idx     <= '0;
            run     <= '0;
            zpend   <= '0;
            hold    <= '0;
            sym_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state   <= state_d;
            idx     <= idx_d;
            run     <= run_d;
            zpend   <= zpend_d;
            hold    <= hold_d;
            sym_q   <= sym_d;
            valid_q <= valid_d;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_run   = sym_q.run;
    assign bus.out_size  = sym_q.size;
    assign bus.out_amp   = sym_q.amp;
    assign bus.out_dc    = sym_q.dc;
    assign bus.out_eob   = sym_q.eob;
    assign bus.out_zrl   = sym_q.zrl;

`ifdef JPEG_RLE_ERRCHK_EN
    logic err;
    always_ff @(posedge clk) begin
        if (!rst_n)
            err <= 1'b0;
        else if (accept && (bus.in_zero != (bus.in_coef == '0)))
            err <= 1'b1;
    end
    assign bus.err = err;
`else
    assign bus.err = 1'b0;
`endif
endmodule

// File: tb/tb_jpeg_rle_encoder.sv
// tb_jpeg_rle_encoder: directed table and corner-sequence checks for jpeg_rle_encoder
module tb_jpeg_rle_encoder;
    typedef struct packed {
        logic [3:0]  run;
        logic [3:0]  size;
        logic [11:0] amp;
        logic        dc;
        logic        eob;
        logic        zrl;
    } sym_t;
    typedef struct {
        logic [11:0] coef;
        logic        zero;
        logic [3:0]  size;
        logic [11:0] amp;
    } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   vectors = 0;
    int   miscompares = 0;
    int   lowcnt = 0;
    sym_t q[$];
    vec_t tbl[11];

    jpeg_rle_encoder_if bus ();
    jpeg_rle_encoder dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    always begin
        @(negedge clk);
        #1;
        if (rst_n && bus.out_valid && bus.out_ready)
            q.push_back({bus.out_run, bus.out_size, bus.out_amp, bus.out_dc, bus.out_eob, bus.out_zrl});
        if (rst_n && !bus.in_ready)
            lowcnt++;
    end

    function automatic sym_t mk(int r, int s, int a, bit dc = 0, bit eob = 0, bit zrl = 0);
        return {4'(r), 4'(s), 12'(a), dc, eob, zrl};
    endfunction

    function automatic void cmp(string nm, logic [63:0] got, logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endfunction

    task automatic send(input logic [11:0] c, input logic z);
        int n = 0;
        bus.in_valid = 1'b1;
        bus.in_coef  = c;
        bus.in_zero  = z;
        #1;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!bus.in_ready) begin
            $display("FAIL send_timeout: in_ready stuck low");
            $fatal(1, "in_ready never asserted");
        end
        @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
    endtask

    task automatic zeros(input int n);
        for (int i = 0; i < n; i++) send(12'd0, 1'b1);
    endtask

    task automatic expect_sym(input string nm, input sym_t e);
        int n = 0;
        while (q.size() == 0 && n < 200) begin
            @(negedge clk);
            #2;
            n++;
        end
        if (q.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: got no symbol expected %h", nm, e);
        end else
            cmp(nm, q.pop_front(), e);
    endtask

    task automatic expect_none(input string nm);
        repeat (4) @(negedge clk);
        cmp(nm, q.size(), 0);
    endtask

    initial begin
        tbl[0]  = '{12'd5,     1'b0, 4'd3,  12'd5};
        tbl[1]  = '{-12'sd3,   1'b0, 4'd2,  12'd0};
        tbl[2]  = '{12'd0,     1'b1, 4'd0,  12'd0};
        tbl[3]  = '{12'd1,     1'b0, 4'd1,  12'd1};
        tbl[4]  = '{-12'sd1,   1'b0, 4'd1,  12'd0};
        tbl[5]  = '{12'd255,   1'b0, 4'd8,  12'd255};
        tbl[6]  = '{-12'sd256, 1'b0, 4'd9,  12'd255};
        tbl[7]  = '{12'd2047,  1'b0, 4'd11, 12'd2047};
        tbl[8]  = '{-12'sd2047,1'b0, 4'd11, 12'd0};
        tbl[9]  = '{-12'sd100, 1'b0, 4'd7,  12'd27};
        tbl[10] = '{12'd64,    1'b0, 4'd7,  12'd64};
        bus.in_valid  = 1'b0;
        bus.in_coef   = '0;
        bus.in_zero   = 1'b0;
        bus.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        #1;
        cmp("reset_out", {bus.out_valid, bus.out_run, bus.out_size, bus.out_amp, bus.out_dc, bus.out_eob, bus.out_zrl}, 0);
        cmp("reset_ready_err", {bus.in_ready, bus.err}, 2'b10);
        @(negedge clk);

        // Each table entry is a block: DC coefficient then 63 zeros -> DC then EOB
        for (int i = 0; i < 11; i++) begin
            send(tbl[i].coef, tbl[i].zero);
            zeros(63);
            expect_sym($sformatf("dc_tbl%0d", i), mk(0, tbl[i].size, tbl[i].amp, 1));
            expect_sym($sformatf("eob_tbl%0d", i), mk(0, 0, 0, 0, 1));
        end
        expect_none("tbl_no_extra");

        send(-12'sd3, 1'b0);
        send(-12'sd1, 1'b0);
        zeros(62);
        expect_sym("neg_dc", mk(0, 2, 0, 1));
        expect_sym("neg_ac1", mk(0, 1, 0));
        expect_sym("neg_eob", mk(0, 0, 0, 0, 1));
        expect_none("neg_no_extra");

        lowcnt = 0;
        send(12'd0, 1'b1);
        zeros(20);
        send(12'd1, 1'b0);
        zeros(42);
        expect_sym("zrl1_dc", mk(0, 0, 0, 1));
        expect_sym("zrl1_zrl", mk(15, 0, 0, 0, 0, 1));
        expect_sym("zrl1_ac", mk(4, 1, 1));
        expect_sym("zrl1_eob", mk(0, 0, 0, 0, 1));
        expect_none("zrl1_no_extra");
        cmp("zrl1_ready_low", lowcnt, 1);

        lowcnt = 0;
        send(12'd0, 1'b1);
        zeros(62);
        send(12'd7, 1'b0);
        expect_sym("zrl3_dc", mk(0, 0, 0, 1));
        for (int i = 0; i < 3; i++) expect_sym($sformatf("zrl3_zrl%0d", i), mk(15, 0, 0, 0, 0, 1));
        expect_sym("zrl3_ac63", mk(14, 3, 7));
        expect_none("zrl3_no_eob");
        cmp("zrl3_ready_low", lowcnt, 3);

        // Backpressure: DC stalls in the output register for 5 cycles
        bus.out_ready = 1'b0;
        send(12'd9, 1'b0);
        repeat (5) begin
            #1;
            cmp("bp_hold", {bus.out_valid, bus.out_run, bus.out_size, bus.out_amp, bus.out_dc, bus.out_eob, bus.out_zrl, bus.in_ready},
                {1'b1, 4'd0, 4'd4, 12'd9, 3'b100, 1'b0});
            @(negedge clk);
        end
        bus.out_ready = 1'b1;
        send(12'd2, 1'b0);
        zeros(62);
        expect_sym("bp_dc", mk(0, 4, 9, 1));
        expect_sym("bp_ac", mk(0, 2, 2));
        expect_sym("bp_eob", mk(0, 0, 0, 0, 1));
        expect_none("bp_no_extra");

        // Reset mid-block at idx 30 with run=9
        send(12'd1, 1'b0);
        zeros(19);
        send(12'd1, 1'b0);
        zeros(9);
        expect_sym("rst_pre_dc", mk(0, 1, 1, 1));
        expect_sym("rst_pre_zrl", mk(15, 0, 0, 0, 0, 1));
        expect_sym("rst_pre_ac", mk(3, 1, 1));
        expect_none("rst_pre_no_extra");
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        #1;
        cmp("rst_mid_out", {bus.out_valid, bus.in_ready, bus.err}, 3'b010);
        @(negedge clk);
        send(12'd6, 1'b0);
        zeros(63);
        expect_sym("rst_post_dc", mk(0, 3, 6, 1));
        expect_sym("rst_post_eob", mk(0, 0, 0, 0, 1));
        expect_none("rst_post_no_extra");

        // Flag mismatch: encoding follows in_zero
        send(12'd3, 1'b1);
        zeros(63);
        expect_sym("err_dc", mk(0, 0, 0, 1));
        expect_sym("err_eob", mk(0, 0, 0, 0, 1));
`ifdef JPEG_RLE_ERRCHK_EN
        cmp("err_flag", bus.err, 1);
`else
        cmp("err_flag", bus.err, 0);
`endif
        expect_none("err_no_extra");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
